// File: rtl/bcd_seg_scanner_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; pins are inverted in the top.
package bcd_seg_scanner_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 8;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    // Active-low pin levels for a dark display.
    localparam logic [6:0]            SEG_OFF = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] AN_OFF  = '1;

    typedef enum logic {
        ST_UNPRIMED,
        ST_PRIMED
    } prime_state_t;

endpackage

// File: rtl/bcd_seg_scanner_if.sv
// Display-side bundle: digit/dp requests in, segment/anode pins out.
interface bcd_seg_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    import bcd_seg_scanner_pkg::*;

    logic                          enable;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]         dp_in;
    logic [6:0]                    seg_out;
    logic                          dp_out;
    logic [NUM_DIGITS-1:0]         an_out;
    logic                          frame_start;

    modport master (
        output enable, bcd_in, dp_in,
        input  seg_out, dp_out, an_out, frame_start
    );

    modport slave (
        input  enable, bcd_in, dp_in,
        output seg_out, dp_out, an_out, frame_start
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a}.
// Codes 10..15 render as a dash so corrupt counter values stay visible.
module bcd_to_7seg
    import bcd_seg_scanner_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed common-anode display driver with leading-zero blanking,
// per-slot anode guard interval and once-per-frame input sampling.
module bcd_seg_scanner
    import bcd_seg_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 16,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    bcd_seg_scanner_if.slave bus
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [PRESC_W-1:0] GUARD_CNT  = PRESC_W'(GUARD);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);

    prime_state_t                  state_reg, state_next;
    logic [PRESC_W-1:0]            presc_reg, presc_next;
    logic [IDX_W-1:0]              idx_reg, idx_next;
    logic [DIGIT_W*NUM_DIGITS-1:0] shadow_bcd_reg;
    logic [NUM_DIGITS-1:0]         shadow_dp_reg;

    logic [6:0]                    seg_reg, seg_next;
    logic                          dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]         an_reg, an_next;
    logic                          frame_start_reg;

    logic                          tick;
    logic                          load;
    logic [DIGIT_W-1:0]            digit_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]         blank_vec;
    logic [6:0]                    seg_raw;

    assign tick = bus.enable && (presc_reg == PRESC_LAST);

    // Priming and scan advance; load marks a shadow capture (also frame_start).
    always_comb begin
        state_next = state_reg;
        presc_next = presc_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        if (bus.enable) begin
            presc_next = tick ? '0 : presc_reg + PRESC_ONE;
            if (tick) begin
                idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_ONE;
            end
            case (state_reg)
                ST_UNPRIMED: begin
                    load       = 1'b1;
                    state_next = ST_PRIMED;
                end
                default: load = tick && (idx_reg == IDX_LAST);
            endcase
        end
    end

    // A digit blanks only if it and everything above it is zero and no dp
    // at or above it asks for the digit to be shown.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic upper_zero;
        logic dp_force;

        assign digit_arr[gi] = shadow_bcd_reg[gi*DIGIT_W +: DIGIT_W];

        always_comb begin
            upper_zero = 1'b1;
            dp_force   = 1'b0;
            for (int j = gi; j < NUM_DIGITS; j++) begin
                if (shadow_bcd_reg[j*DIGIT_W +: DIGIT_W] != '0) upper_zero = 1'b0;
                if (shadow_dp_reg[j]) dp_force = 1'b1;
            end
        end

        assign blank_vec[gi] = BLANK_LZ && (gi != 0) && upper_zero && !dp_force;
    end

    bcd_to_7seg u_dec (
        .digit (digit_arr[idx_reg]),
        .seg   (seg_raw)
    );

    always_comb begin
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        an_next  = AN_OFF[NUM_DIGITS-1:0];
        if (bus.enable) begin
            seg_next = blank_vec[idx_reg] ? SEG_OFF : ~seg_raw;
            dp_next  = ~shadow_dp_reg[idx_reg];
            if (presc_reg >= GUARD_CNT) an_next[idx_reg] = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_UNPRIMED;
            presc_reg       <= '0;
            idx_reg         <= '0;
            shadow_bcd_reg  <= '0;
            shadow_dp_reg   <= '0;
            seg_reg         <= SEG_OFF;
            dp_reg          <= 1'b1;
            an_reg          <= AN_OFF[NUM_DIGITS-1:0];
            frame_start_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            idx_reg         <= idx_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
            an_reg          <= an_next;
            frame_start_reg <= load;
            if (load) begin
                shadow_bcd_reg <= bus.bcd_in;
                shadow_dp_reg  <= bus.dp_in;
            end
        end
    end

    assign bus.seg_out     = seg_reg;
    assign bus.dp_out      = dp_reg;
    assign bus.an_out      = an_reg;
    assign bus.frame_start = frame_start_reg;

endmodule
